lsb_ctl: RTL and testbench

Arbiter and sequencer in front of the LEDs/switches/buttons (LSB) register slave. It shares the slave's single strobe interface between three requesters: the CPU IO bus, one hardware requester, and an optional internal heartbeat blinker. It is the only master driving the LSB slave. Every granted access becomes exactly one single-cycle slave strobe. A shadow of the CPU-written system-LED byte is kept so that non-CPU writes never clobber the system LEDs.

---
 rtl/lsb_ctl.sv | 202 ++++++++++++++++++++
 tb/tb_lsb_ctl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/lsb_ctl.sv
// ============================================================================
// Module      : lsb_ctl
// Description : Round-robin arbiter/sequencer that owns the LSB slave strobe
//               port for the CPU, a hardware requester and an optional
//               heartbeat blinker (built when LSB_CTL_HEARTBEAT_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsb_ctl #(
    parameter int unsigned HB_DIV = 20_000_000,
    parameter int unsigned HB_LED = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_stb,
    input  logic        cpu_we,
    input  logic [31:0] cpu_data_in,
    output logic [31:0] cpu_data_out,
    output logic        cpu_ack,
    input  logic        hw_req,
    input  logic [31:0] hw_data,
    output logic        hw_ack,
    output logic        lsb_stb,
    output logic        lsb_we,
    output logic [31:0] lsb_data_in,
    input  logic [31:0] lsb_data_out,
    input  logic        lsb_ack
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    localparam logic [1:0] C_REQ_CPU = 2'd0;
    localparam logic [1:0] C_REQ_HW  = 2'd1;
    localparam logic [1:0] C_REQ_HB  = 2'd2;
`ifdef LSB_CTL_HEARTBEAT_EN
    localparam int C_NREQ = 3;
`else
    localparam int C_NREQ = 2;
`endif
    localparam logic [1:0] C_LAST_IDX = 2'(C_NREQ - 1);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  last_q, last_d;
    logic [7:0]  sys_shadow_q, sys_shadow_d;

    logic        w_hb_pend;
    logic [31:0] w_hb_word;
    logic [2:0]  w_req;
    logic [1:0]  w_start;
    logic [2:0]  w_sum;
    logic [1:0]  w_idx;
    logic [1:0]  w_pick;
    logic        w_found;
    logic        w_grant;
    logic        w_xfer;
    logic        w_unused;

    assign w_req   = {w_hb_pend, hw_req, cpu_stb};
    assign w_grant = (state_q == S_IDLE) && w_found;
    // Reset aborts an in-flight transfer within the same cycle, so no ack escapes.
    assign w_xfer  = (state_q == S_XFER) && !rst;

    always_comb begin
        w_pick  = 2'd0;
        w_found = 1'b0;
        w_sum   = 3'd0;
        w_idx   = 2'd0;
        w_start = (last_q >= C_LAST_IDX) ? 2'd0 : last_q + 2'd1;
        for (int k = 0; k < C_NREQ; k++) begin
            w_sum = {1'b0, w_start} + 3'(k);
            if (w_sum > 3'(C_LAST_IDX)) begin
                w_sum = w_sum - 3'(C_NREQ);
            end
            w_idx = w_sum[1:0];
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

`ifdef LSB_CTL_HEARTBEAT_EN
    localparam int unsigned C_CNT_W = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;

    logic [C_CNT_W-1:0] hb_cnt_q, hb_cnt_d;
    logic               hb_level_q, hb_level_d;
    logic               hb_pend_q, hb_pend_d;
    logic               w_wrap;
    logic [3:0]         w_led_mask;

    assign w_wrap     = (hb_cnt_q == C_CNT_W'(HB_DIV - 1));
    assign w_led_mask = 4'b0001 << HB_LED[1:0];
    assign w_hb_pend  = hb_pend_q;
    assign w_hb_word  = {(hb_level_q ? 2'b10 : 2'b01), 18'd0, w_led_mask, sys_shadow_q};
    assign w_unused   = &{1'b0, lsb_ack, hw_data[7:0]};

    // A wrap in the grant cycle wins, leaving a fresh request pending.
    always_comb begin
        hb_cnt_d   = w_wrap ? '0 : hb_cnt_q + 1'b1;
        hb_level_d = hb_level_q ^ w_wrap;
        hb_pend_d  = hb_pend_q;
        if (w_grant && (w_pick == C_REQ_HB)) begin
            hb_pend_d = 1'b0;
        end
        if (w_wrap) begin
            hb_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt_q   <= '0;
            hb_level_q <= 1'b0;
            hb_pend_q  <= 1'b0;
        end else begin
            hb_cnt_q   <= hb_cnt_d;
            hb_level_q <= hb_level_d;
            hb_pend_q  <= hb_pend_d;
        end
    end
`else
    assign w_hb_pend = 1'b0;
    assign w_hb_word = 32'd0;
    assign w_unused  = &{1'b0, lsb_ack, hw_data[7:0], HB_DIV[0], HB_LED[0]};
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        sys_shadow_d = sys_shadow_q;
        case (state_q)
            S_IDLE: begin
                if (w_grant) begin
                    state_d = S_XFER;
                    grant_d = w_pick;
                    last_d  = w_pick;
                end
            end
            S_XFER: begin
                state_d = S_IDLE;
                if ((grant_q == C_REQ_CPU) && cpu_we) begin
                    sys_shadow_d = cpu_data_in[7:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lsb_stb      = 1'b0;
        lsb_we       = 1'b0;
        lsb_data_in  = 32'd0;
        cpu_ack      = 1'b0;
        cpu_data_out = 32'd0;
        hw_ack       = 1'b0;
        if (w_xfer) begin
            lsb_stb = 1'b1;
            case (grant_q)
                C_REQ_CPU: begin
                    lsb_we      = cpu_we;
                    lsb_data_in = cpu_data_in;
                    cpu_ack     = 1'b1;
                    if (!cpu_we) begin
                        cpu_data_out = lsb_data_out;
                    end
                end
                C_REQ_HW: begin
                    lsb_we      = 1'b1;
                    lsb_data_in = {hw_data[31:8], sys_shadow_q};
                    hw_ack      = 1'b1;
                end
                default: begin
                    lsb_we      = 1'b1;
                    lsb_data_in = w_hb_word;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= C_REQ_CPU;
            last_q       <= C_REQ_HB;
            sys_shadow_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            sys_shadow_q <= sys_shadow_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsb_ctl.sv
// ============================================================================
// Module      : tb_lsb_ctl
// Description : Directed scoreboard bench for lsb_ctl; heartbeat scenario is
//               selected when LSB_CTL_HEARTBEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsb_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_stb, cpu_we, hw_req, lsb_ack;
    logic [31:0] cpu_data_in, hw_data, lsb_data_out;
    logic [31:0] cpu_data_out, lsb_data_in;
    logic        cpu_ack, hw_ack, lsb_stb, lsb_we;

    lsb_ctl #(.HB_DIV(4), .HB_LED(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_stb      (cpu_stb),
        .cpu_we       (cpu_we),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .cpu_ack      (cpu_ack),
        .hw_req       (hw_req),
        .hw_data      (hw_data),
        .hw_ack       (hw_ack),
        .lsb_stb      (lsb_stb),
        .lsb_we       (lsb_we),
        .lsb_data_in  (lsb_data_in),
        .lsb_data_out (lsb_data_out),
        .lsb_ack      (lsb_ack)
    );

    always #5 clk = ~clk;
    assign lsb_ack = lsb_stb;

    typedef struct {
        logic        we;
        logic [31:0] data;
        logic        cpu;
        logic [31:0] rd;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         total  = 0;
    int         passed = 0;
    logic [7:0] m_shadow = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (lsb_stb === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_stb", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("lsb_we", {31'd0, lsb_we}, {31'd0, mon_e.we});
                chk("lsb_data_in", lsb_data_in, mon_e.data);
                chk("cpu_ack", {31'd0, cpu_ack}, {31'd0, mon_e.cpu});
                chk("hw_ack", {31'd0, hw_ack}, {31'd0, !mon_e.cpu});
                chk("cpu_data_out", cpu_data_out, mon_e.rd);
            end
        end else begin
            chk("idle_acks", {30'd0, cpu_ack, hw_ack}, 32'd0);
            chk("idle_rdata", cpu_data_out, 32'd0);
        end
    end

    task automatic push(input logic we, input logic [31:0] data, input logic cpu, input logic [31:0] rd);
        exp_t e;
        e.we = we; e.data = data; e.cpu = cpu; e.rd = rd;
        sb.push_back(e);
    endtask

    // Entered one step after a posedge with the FSM idle.
    task automatic xfer(input bit is_cpu, input logic we, input logic [31:0] d, input logic [31:0] rd);
        lsb_data_out = rd;
        if (is_cpu) begin
            cpu_stb = 1'b1; cpu_we = we; cpu_data_in = d;
            push(we, d, 1'b1, we ? 32'd0 : rd);
            if (we) m_shadow = d[7:0];
        end else begin
            hw_req = 1'b1; hw_data = d;
            push(1'b1, {d[31:8], m_shadow}, 1'b0, 32'd0);
        end
        @(posedge clk); #1;
        chk("grant_latency", {31'd0, lsb_stb}, 32'd1);
        cpu_stb = 1'b0;
        hw_req  = 1'b0;
        @(posedge clk); #1;
        chk("idle_gap", {31'd0, lsb_stb}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cpu_stb = 1'b0; cpu_we = 1'b0; hw_req = 1'b0;
        cpu_data_in = 32'd0; hw_data = 32'd0; lsb_data_out = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stb", {31'd0, lsb_stb}, 32'd0);
        chk("rst_data", lsb_data_in, 32'd0);
        chk("rst_acks", {30'd0, cpu_ack, hw_ack}, 32'd0);
        rst = 1'b0;

`ifdef LSB_CTL_HEARTBEAT_EN
        push(1'b1, 32'h8000_0400, 1'b0, 32'd0);
        push(1'b1, 32'h4000_0400, 1'b0, 32'd0);
        push(1'b1, 32'h8000_0400, 1'b0, 32'd0);
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            chk("hb_stb", {31'd0, lsb_stb}, {31'd0, (k == 5 || k == 9 || k == 13)});
        end
        rst = 1'b1;
        @(posedge clk); #1;
`else
        xfer(1'b1, 1'b1, 32'hC000_00A5, 32'd0);
        xfer(1'b0, 1'b1, 32'h8000_0F33, 32'd0);
        xfer(1'b1, 1'b0, 32'h1111_1111, 32'h0000_0305);
        @(posedge clk); #1;

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_shadow = 8'h00;

        // Both requesters held: grants alternate starting with the CPU.
        cpu_stb = 1'b1; cpu_we = 1'b1; cpu_data_in = 32'h8000_0111;
        hw_req = 1'b1; hw_data = 32'hAAAA_AA00; lsb_data_out = 32'd0;
        push(1'b1, 32'h8000_0111, 1'b1, 32'd0);
        push(1'b1, 32'hAAAA_AA11, 1'b0, 32'd0);
        push(1'b1, 32'h4000_0222, 1'b1, 32'd0);
        push(1'b1, 32'h5555_5522, 1'b0, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk("alt_stb", {31'd0, lsb_stb}, {31'd0, k[0]});
            if (k == 2) cpu_data_in = 32'h4000_0222;
            if (k == 4) hw_data = 32'h5555_5500;
            if (k == 7) begin
                cpu_stb = 1'b0;
                hw_req  = 1'b0;
            end
        end
        m_shadow = 8'h22;

        // Reset during XFER of a CPU write aborts it; the held request is retried.
        cpu_stb = 1'b1; cpu_we = 1'b1; cpu_data_in = 32'h4000_003C;
        @(posedge clk); #1;
        chk("abort_pre_stb", {31'd0, lsb_stb}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_no_ack", {31'd0, cpu_ack}, 32'd0);
        @(posedge clk); #1;
        chk("abort_stb", {31'd0, lsb_stb}, 32'd0);
        chk("abort_shadow", {24'd0, dut.sys_shadow_q}, 32'd0);
        rst = 1'b0;
        push(1'b1, 32'h4000_003C, 1'b1, 32'd0);
        m_shadow = 8'h3C;
        @(posedge clk); #1;
        chk("retry_stb", {31'd0, lsb_stb}, 32'd1);
        cpu_stb = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, 1'b1, 32'h1234_5678, 32'd0);

        // Without the heartbeat an idle controller never strobes.
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            chk("no_hb_stb", {31'd0, lsb_stb}, 32'd0);
        end
`endif
        @(posedge clk); #1;
        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
